// File: rtl/vec_agu_pkg.sv
// Shared types and sizing for the multi-port vector address generator.
package vec_agu_pkg;

  localparam int unsigned AGU_VLEN       = 16384;
  localparam int unsigned AGU_DATA_WIDTH = 64;
  localparam int unsigned AGU_ADDR_WIDTH = 5;
  localparam int unsigned AGU_NPORT      = 3;
  localparam int unsigned AGU_SHIFT_W    = 2;

  // Beat counter width: register index bits plus word-offset bits.
  function automatic int unsigned cw_f(input int unsigned addr_w,
                                       input int unsigned vlen,
                                       input int unsigned data_w);
    return addr_w + $clog2(vlen / data_w);
  endfunction

  localparam int unsigned AGU_OFF_WIDTH = $clog2(AGU_VLEN / AGU_DATA_WIDTH);
  localparam int unsigned AGU_CW        = cw_f(AGU_ADDR_WIDTH, AGU_VLEN, AGU_DATA_WIDTH);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Command fields captured at acceptance; first beat goes straight into the counter.
  typedef struct packed {
    logic [AGU_NPORT-1:0][AGU_ADDR_WIDTH-1:0] base;
    logic [AGU_NPORT-1:0][AGU_SHIFT_W-1:0]    shift;
    logic [AGU_CW-1:0]                        last;
  } cmd_t;

endpackage

// File: rtl/vec_agu_port_calc.sv
// Per-port word address: base register scaled to words plus the repeat-shifted beat index.
module vec_agu_port_calc #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned OFF_WIDTH  = 8,
  parameter int unsigned SHIFT_W    = 2,
  localparam int unsigned CW        = ADDR_WIDTH + OFF_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [SHIFT_W-1:0]    shift,
  input  logic [CW-1:0]         b,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [OFF_WIDTH-1:0]  off
);

  logic [CW-1:0] word;

  // Sum truncates to CW bits, so running past the top register wraps to register 0.
  assign word = {base, {OFF_WIDTH{1'b0}}} + (b >> shift);
  assign addr = word[CW-1:OFF_WIDTH];
  assign off  = word[OFF_WIDTH-1:0];

endmodule

// File: rtl/vec_addr_gen_mp.sv
// Multi-port vector register-file address generator: one command -> a burst of per-port beats.
module vec_addr_gen_mp
  import vec_agu_pkg::*;
#(
  parameter int unsigned VLEN       = AGU_VLEN,
  parameter int unsigned DATA_WIDTH = AGU_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = AGU_ADDR_WIDTH,
  parameter int unsigned NPORT      = AGU_NPORT,
  parameter int unsigned SHIFT_W    = AGU_SHIFT_W,
  localparam int unsigned OFF_WIDTH = $clog2(VLEN / DATA_WIDTH),
  localparam int unsigned CW        = cw_f(ADDR_WIDTH, VLEN, DATA_WIDTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [NPORT*ADDR_WIDTH-1:0] cmd_base,
  input  logic [NPORT*SHIFT_W-1:0]    cmd_shift,
  input  logic [CW-1:0]               cmd_first,
  input  logic [CW-1:0]               cmd_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NPORT*ADDR_WIDTH-1:0] out_addr,
  output logic [NPORT*OFF_WIDTH-1:0]  out_off,
  output logic [CW-1:0]               out_beat,
  output logic                        out_start,
  output logic                        out_end,
  output logic                        idle
);

  state_t        state, state_nxt;
  logic [CW-1:0] b, b_nxt;
  cmd_t          cmd, cmd_nxt;
  logic          valid_nxt, start_nxt, end_nxt;
  logic          accept;

  logic [NPORT-1:0][ADDR_WIDTH-1:0] addr_nxt;
  logic [NPORT-1:0][OFF_WIDTH-1:0]  off_nxt;

  // A new command is taken when idle, or when the end beat of the current burst is consumed.
  assign cmd_ready = !rst && !flush &&
                     ((state == S_IDLE) || (out_ready && out_end));
  assign accept    = cmd_valid && cmd_ready;

  // State, beat counter and captured command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      b     <= '0;
      cmd   <= '0;
    end else begin
      state <= state_nxt;
      b     <= b_nxt;
      cmd   <= cmd_nxt;
    end
  end

  // Next-state: flush wins, then command acceptance, then beat consumption.
  always_comb begin
    state_nxt = state;
    b_nxt     = b;
    cmd_nxt   = cmd;
    valid_nxt = out_valid;
    start_nxt = out_start;
    end_nxt   = out_end;
    if (flush) begin
      state_nxt = S_IDLE;
      valid_nxt = 1'b0;
      start_nxt = 1'b0;
      end_nxt   = 1'b0;
    end else if (accept) begin
      state_nxt     = S_RUN;
      b_nxt         = cmd_first;
      cmd_nxt.base  = cmd_base;
      cmd_nxt.shift = cmd_shift;
      cmd_nxt.last  = cmd_last;
      valid_nxt     = 1'b1;
      start_nxt     = 1'b1;
      // last < first still yields exactly one beat, so it also ends immediately.
      end_nxt       = (cmd_first >= cmd_last);
    end else if ((state == S_RUN) && out_ready) begin
      if (out_end) begin
        state_nxt = S_IDLE;
        valid_nxt = 1'b0;
        start_nxt = 1'b0;
        end_nxt   = 1'b0;
      end else begin
        b_nxt     = b + CW'(1);
        start_nxt = 1'b0;
        end_nxt   = ((b + CW'(1)) >= cmd.last);
      end
    end
  end

  // One address calculator per operand stream, fed by the next-cycle counter and command.
  for (genvar p = 0; p < NPORT; p++) begin : g_port
    vec_agu_port_calc #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .OFF_WIDTH  (OFF_WIDTH),
      .SHIFT_W    (SHIFT_W)
    ) u_calc (
      .base  (cmd_nxt.base[p]),
      .shift (cmd_nxt.shift[p]),
      .b     (b_nxt),
      .addr  (addr_nxt[p]),
      .off   (off_nxt[p])
    );
  end

  // Registered beat outputs; they only change on a transition, so stalls hold them.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_start <= 1'b0;
      out_end   <= 1'b0;
      out_addr  <= '0;
      out_off   <= '0;
      out_beat  <= '0;
      idle      <= 1'b1;
    end else begin
      out_valid <= valid_nxt;
      out_start <= start_nxt;
      out_end   <= end_nxt;
      out_addr  <= addr_nxt;
      out_off   <= off_nxt;
      out_beat  <= b_nxt;
      idle      <= (state_nxt == S_IDLE);
    end
  end

endmodule

// File: tb/tb_vec_addr_gen_mp.sv
// Self-checking bench for vec_addr_gen_mp: burst-list model plus directed literal checks.
module tb_vec_addr_gen_mp;

  localparam int AW = 5;
  localparam int OW = 8;
  localparam int CW = 13;
  localparam int NP = 3;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst, flush, cmd_valid, out_ready;
  logic            cmd_ready, out_valid, out_start, out_end, idle;
  logic [NP*AW-1:0] cmd_base, out_addr;
  logic [NP*SW-1:0] cmd_shift;
  logic [CW-1:0]   cmd_first, cmd_last, out_beat;
  logic [NP*OW-1:0] out_off;

  int n_checks = 0;
  int n_pass   = 0;
  bit started  = 1'b0;

  typedef struct {
    int              b;
    bit              st;
    bit              en;
    logic [NP*AW-1:0] base;
    logic [NP*SW-1:0] sh;
  } beat_t;
  beat_t q[$];

  always #5 clk = ~clk;

  vec_addr_gen_mp dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_base  (cmd_base),
    .cmd_shift (cmd_shift),
    .cmd_first (cmd_first),
    .cmd_last  (cmd_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_off   (out_off),
    .out_beat  (out_beat),
    .out_start (out_start),
    .out_end   (out_end),
    .idle      (idle)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Word index of a port: base register times words-per-register plus the repeated beat.
  function automatic int mword(input int base, input int sh, input int b);
    return (base * 256 + (b >> sh)) % 8192;
  endfunction

  // Model: a list of pending beats; acceptance and consumption decided from the list alone.
  int   m_n, m_first, m_last;
  bit   m_ready;
  beat_t m_f, m_nb;
  always @(negedge clk) begin
    if (started) begin
      m_ready = !rst && !flush && (q.size() == 0 || (out_ready && q[0].en));
      chk("cmd_ready", 32'(cmd_ready), 32'(m_ready));
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("idle",      32'(idle),      32'(q.size() == 0));
      if (q.size() != 0) begin
        m_f = q[0];
        chk("out_beat",  32'(out_beat),  32'(m_f.b));
        chk("out_start", 32'(out_start), 32'(m_f.st));
        chk("out_end",   32'(out_end),   32'(m_f.en));
        for (int p = 0; p < NP; p++) begin
          int w;
          w = mword(int'(m_f.base[p*AW +: AW]), int'(m_f.sh[p*SW +: SW]), m_f.b);
          chk($sformatf("addr%0d", p), 32'(out_addr[p*AW +: AW]), 32'(w / 256));
          chk($sformatf("off%0d", p),  32'(out_off[p*OW +: OW]),  32'(w % 256));
        end
      end else begin
        chk("start_idle", 32'(out_start), 32'(0));
        chk("end_idle",   32'(out_end),   32'(0));
      end
      if (rst || flush) begin
        q.delete();
      end else begin
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (cmd_valid && m_ready) begin
          m_first = int'(cmd_first);
          m_last  = int'(cmd_last);
          m_n = (m_last >= m_first) ? (m_last - m_first + 1) : 1;
          for (int i = 0; i < m_n; i++) begin
            m_nb.b = m_first + i;
            m_nb.st = (i == 0);
            m_nb.en = (i == m_n - 1);
            m_nb.base = cmd_base;
            m_nb.sh = cmd_shift;
            q.push_back(m_nb);
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offer a command and hold it until the DUT takes it (bounded).
  task automatic send(input logic [NP*AW-1:0] base, input logic [NP*SW-1:0] sh,
                      input int first, input int last);
    bit r, done;
    done = 1'b0;
    cmd_base  = base;
    cmd_shift = sh;
    cmd_first = CW'(first);
    cmd_last  = CW'(last);
    cmd_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      r = cmd_ready;
      tick();
      if (r) begin
        done = 1'b1;
        break;
      end
    end
    cmd_valid = 1'b0;
    chk("accepted", 32'(done), 32'(1));
  endtask

  function automatic logic [NP*AW-1:0] bases(input int b2, input int b1, input int b0);
    return {AW'(b2), AW'(b1), AW'(b0)};
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; cmd_valid = 1'b0; out_ready = 1'b1;
    cmd_base = '0; cmd_shift = '0; cmd_first = '0; cmd_last = '0;
    @(posedge clk);
    started = 1'b1;
    #1;
    tick();
    chk("rst_idle",  32'(idle),      32'(1));
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_ready", 32'(cmd_ready), 32'(0));
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(cmd_ready), 32'(1));

    // Single port burst 0..2 on register 3.
    send(bases(0, 0, 3), '0, 0, 2);
    chk("t1_addr0", 32'(out_addr[4:0]), 32'(3));
    chk("t1_off0",  32'(out_off[7:0]),  32'(0));
    chk("t1_start", 32'(out_start),     32'(1));
    tick();
    chk("t1_off1",  32'(out_off[7:0]),  32'(1));
    tick();
    chk("t1_off2",  32'(out_off[7:0]),  32'(2));
    chk("t1_end",   32'(out_end),       32'(1));
    tick();
    chk("t1_idle",  32'(idle),          32'(1));

    // Widening: port1 repeats every second beat, port2 every fourth.
    send(bases(1, 4, 8), {2'd2, 2'd1, 2'd0}, 0, 3);
    chk("t2_p1_off_b0", 32'(out_off[15:8]), 32'(0));
    tick();
    chk("t2_p0_off_b1", 32'(out_off[7:0]),  32'(1));
    chk("t2_p1_off_b1", 32'(out_off[15:8]), 32'(0));
    tick();
    chk("t2_p1_off_b2", 32'(out_off[15:8]), 32'(1));
    chk("t2_p1_addr",   32'(out_addr[9:5]), 32'(4));
    tick();
    chk("t2_p0_off_b3", 32'(out_off[7:0]),  32'(3));
    tick();

    // Wrap past register 31.
    send(bases(0, 0, 31), '0, 255, 256);
    chk("t3_addr_a", 32'(out_addr[4:0]), 32'(31));
    chk("t3_off_a",  32'(out_off[7:0]),  32'(255));
    tick();
    chk("t3_addr_b", 32'(out_addr[4:0]), 32'(0));
    chk("t3_off_b",  32'(out_off[7:0]),  32'(0));
    chk("t3_end",    32'(out_end),       32'(1));
    tick();

    // Stall on beat 1, then back-to-back command on the end beat.
    send(bases(0, 0, 2), '0, 0, 3);
    tick();
    out_ready = 1'b0;
    chk("t4_stall_beat", 32'(out_beat), 32'(1));
    tick();
    chk("t4_hold_beat", 32'(out_beat),     32'(1));
    chk("t4_hold_off",  32'(out_off[7:0]), 32'(1));
    tick();
    chk("t4_hold_addr", 32'(out_addr[4:0]), 32'(2));
    out_ready = 1'b1;
    send(bases(0, 0, 10), '0, 7, 8);
    chk("t4_b2b_valid", 32'(out_valid),     32'(1));
    chk("t4_b2b_start", 32'(out_start),     32'(1));
    chk("t4_b2b_beat",  32'(out_beat),      32'(7));
    chk("t4_b2b_addr",  32'(out_addr[4:0]), 32'(10));
    tick();
    tick();

    // last < first: a single beat at first.
    send(bases(0, 0, 6), '0, 5, 2);
    chk("t5_beat",  32'(out_beat),  32'(5));
    chk("t5_start", 32'(out_start), 32'(1));
    chk("t5_end",   32'(out_end),   32'(1));
    tick();
    chk("t5_idle",  32'(idle),      32'(1));

    // Flush on beat 1 of a 10-beat burst with a command pending.
    send(bases(0, 0, 7), '0, 0, 9);
    tick();
    flush = 1'b1;
    cmd_base = bases(0, 0, 9); cmd_first = '0; cmd_last = CW'(1);
    cmd_valid = 1'b1;
    #1;
    chk("t6_ready_low", 32'(cmd_ready), 32'(0));
    tick();
    flush = 1'b0;
    cmd_valid = 1'b0;
    chk("t6_valid", 32'(out_valid), 32'(0));
    chk("t6_idle",  32'(idle),      32'(1));
    tick();
    chk("t6_still_idle", 32'(idle), 32'(1));

    // Reset in the middle of a burst, new command right after release.
    send(bases(0, 0, 5), '0, 0, 9);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("t7_valid", 32'(out_valid), 32'(0));
    chk("t7_addr",  32'(out_addr),  32'(0));
    chk("t7_off",   32'(out_off),   32'(0));
    chk("t7_beat",  32'(out_beat),  32'(0));
    chk("t7_start", 32'(out_start), 32'(0));
    chk("t7_end",   32'(out_end),   32'(0));
    chk("t7_idle",  32'(idle),      32'(1));
    chk("t7_ready", 32'(cmd_ready), 32'(0));
    rst = 1'b0;
    cmd_base = bases(0, 0, 1); cmd_shift = '0; cmd_first = '0; cmd_last = CW'(1);
    cmd_valid = 1'b1;
    #1;
    chk("t7_ready_rel", 32'(cmd_ready), 32'(1));
    tick();
    cmd_valid = 1'b0;
    chk("t7_new_valid", 32'(out_valid),     32'(1));
    chk("t7_new_start", 32'(out_start),     32'(1));
    chk("t7_new_addr",  32'(out_addr[4:0]), 32'(1));
    tick();
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
